fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the five-stage pipelined CPU; feeds the decode stage.
//  Holds the PC, drives the instruction-memory address and selects the next PC (sequential, EX branch, WB PC write).
//  Registers the fetched instruction, PC+8 (R15 read value) and a valid bit for decode.
//  Honours hazard-unit stall/flush and inserts bubbles while instruction memory is not ready.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset (bits [1:0] must be 0)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  StallF        in   1   hold PC (hazard unit)
//  StallD        in   1   hold IF/ID register (hazard unit)
//  FlushD        in   1   squash IF/ID register to bubble (hazard unit)
//  BranchTakenE  in   1   branch resolved taken in EX
//  ALUResultE    in   32  branch target from EX
//  PCSrcW        in   1   instruction in WB writes R15
//  ResultW       in   32  R15 write value from WB
//  InstrF        in   32  instruction-memory read data for address PCF
//  ImemReadyF    in   1   InstrF valid this cycle
//  PCF           out  32  current PC / instruction-memory address
//  InstrD        out  32  instruction to decoder
//  PCPlus8D      out  32  address of InstrD + 8
//  ValidD        out  1   InstrD is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (sync, highest priority, overrides stall/flush/redirect): PCF=RESET_PC, InstrD=0, PCPlus8D=0, ValidD=0.
//  Redirect = BranchTakenE | PCSrcW. Target: BranchTakenE ? ALUResultE : ResultW (EX branch wins when both high).
//  Target bits [1:0] are forced to 0 before loading into PCF.
//  PC update (no reset): redirect -> PCF<=target (redirect overrides StallF; must never be lost);
//   else StallF -> hold; else ImemReadyF -> PCF<=PCF+4 (mod 2^32, FFFF_FFFC wraps to 0000_0000); else hold.
//  IF/ID update, priority order: FlushD -> InstrD=0, ValidD=0, PCPlus8D=0;
//   else StallD -> hold all three;
//   else redirect | StallF | ~ImemReadyF -> bubble (InstrD=0, ValidD=0, PCPlus8D=0);
//   else InstrD<=InstrF, PCPlus8D<=PCF+8, ValidD<=1.
//  Latency: instruction fetched in cycle n is on InstrD in cycle n+1; target fetched the cycle after the redirect.
//  Memory wait: PCF stays stable while ImemReadyF=0; one bubble per wait cycle; no duplicate or skipped fetch.
//  A fetch in flight at redirect is discarded; memory is re-addressed with the target next cycle.
//  StallF=1 with StallD=0 is legal: decode receives bubbles; the held PC is re-fetched when released.
//  No combinational path from any input to PCF; InstrD/PCPlus8D/ValidD are registered.
// TESTING
//  Sequential: reset, ImemReadyF=1, InstrF=PCF-tagged -> PCF 0,4,8,C; InstrD follows one cycle behind, PCPlus8D=addr+8, ValidD=1.
//  Branch: BranchTakenE=1, ALUResultE=32'h0000_0103 at PCF=0x10 -> next PCF=0x100, ValidD=0 that cycle, 0x100 instr valid next.
//  Both redirects: BranchTakenE=1 (0x200) and PCSrcW=1 (0x300) together -> PCF=0x200.
//  Wait states: ImemReadyF=0 for 3 cycles at PCF=0x20 -> PCF held 0x20, three bubbles, then 0x20 instr once, PCF=0x24.
//  Stall/flush: StallF=StallD=1 for 2 cycles -> PCF, InstrD unchanged; FlushD+StallD -> bubble; redirect during StallF -> PCF=target.
//  Wrap/reset: PCF=FFFF_FFFC ready -> PCF=0; reset asserted mid-stall -> PCF=RESET_PC, ValidD=0 next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with its IF/ID pipeline register.
// Holds the PC, selects the next PC and hands fetched instructions or bubbles to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    input  logic [31:0] InstrF,
    input  logic        ImemReadyF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        fetch_ok;

    always_comb begin
        redirect   = BranchTakenE | PCSrcW;
        // The EX branch is younger in program order, so it wins over a WB write to R15.
        target_raw = BranchTakenE ? ALUResultE : ResultW;
        target     = {target_raw[31:2], 2'b00};
        fetch_ok   = ~redirect & ~StallF & ImemReadyF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (redirect) begin
            PCF <= target;
        end else if (!StallF && ImemReadyF) begin
            PCF <= PCF + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= '0;
            PCPlus8D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (fetch_ok) begin
                InstrD   <= InstrF;
                PCPlus8D <= PCF + 32'd8;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= '0;
                PCPlus8D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stimulus against a behavioural pipeline model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW, ImemReadyF;
    logic [31:0] ALUResultE, ResultW, InstrF;
    logic [31:0] PCF, InstrD, PCPlus8D;
    logic        ValidD;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Behavioural model state: the address being fetched and what decode holds.
    logic [31:0] m_pc, m_instr, m_pc8;
    logic        m_valid;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
        .ResultW(ResultW), .InstrF(InstrF), .ImemReadyF(ImemReadyF),
        .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hE5A0_0000;
    endfunction

    // Instruction memory returns address-tagged words.
    assign InstrF = instr_of(PCF);

    task automatic idle();
        reset = 0; StallF = 0; StallD = 0; FlushD = 0;
        BranchTakenE = 0; ALUResultE = '0; PCSrcW = 0; ResultW = '0; ImemReadyF = 1;
    endtask

    // One clock: the model advances by the architectural rules, then outputs settle.
    task automatic step();
        logic        redir, accepted;
        logic [31:0] tgt;
        @(posedge clk);
        redir    = BranchTakenE || PCSrcW;
        tgt      = BranchTakenE ? ALUResultE : ResultW;
        tgt      = tgt & 32'hFFFF_FFFC;
        accepted = !redir && !StallF && ImemReadyF;
        if (reset || FlushD) begin
            m_instr = 0; m_pc8 = 0; m_valid = 0;
        end else if (!StallD) begin
            m_instr = accepted ? instr_of(m_pc) : 32'h0;
            m_pc8   = accepted ? m_pc + 32'd8 : 32'h0;
            m_valid = accepted;
        end
        if (reset)         m_pc = RESET_PC;
        else if (redir)    m_pc = tgt;
        else if (accepted) m_pc = m_pc + 32'd4;
        #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1;
        step(); step();
        n_checks++; if (PCF !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PCF, RESET_PC); end
        n_checks++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", InstrD); end
        n_checks++; if (PCPlus8D !== 32'h0) begin n_fail++; $display("FAIL reset_pc8: got %h want 0", PCPlus8D); end
        n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ValidD); end
        idle();
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            logic [31:0] a;
            a = 32'(4 * (i - 1));
            step();
            n_checks++; if (PCF !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc: got %h want %h", PCF, 32'(4 * i)); end
            n_checks++; if (InstrD !== instr_of(a) || PCPlus8D !== a + 32'd8 || ValidD !== 1'b1) begin
                n_fail++; $display("FAIL seq_d: got %h/%h/%b want %h/%h/1", InstrD, PCPlus8D, ValidD, instr_of(a), a + 32'd8);
            end
        end
    endtask

    task automatic test_branch();
        n_checks++; if (PCF !== 32'h10) begin n_fail++; $display("FAIL br_pre_pc: got %h want 00000010", PCF); end
        BranchTakenE = 1; ALUResultE = 32'h0000_0103;
        step(); idle();
        n_checks++; if (PCF !== 32'h100 || ValidD !== 1'b0) begin n_fail++; $display("FAIL br_redirect: got %h/%b want 00000100/0", PCF, ValidD); end
        step();
        n_checks++; if (PCF !== 32'h104 || InstrD !== instr_of(32'h100) || PCPlus8D !== 32'h108 || ValidD !== 1'b1) begin
            n_fail++; $display("FAIL br_target: got %h/%h/%h/%b want 00000104/%h/00000108/1", PCF, InstrD, PCPlus8D, ValidD, instr_of(32'h100));
        end
    endtask

    task automatic test_both_redirects();
        BranchTakenE = 1; ALUResultE = 32'h200; PCSrcW = 1; ResultW = 32'h300;
        step(); idle();
        n_checks++; if (PCF !== 32'h200 || ValidD !== 1'b0) begin n_fail++; $display("FAIL both_redir: got %h/%b want 00000200/0", PCF, ValidD); end
    endtask

    task automatic test_wait_states();
        PCSrcW = 1; ResultW = 32'h0000_0022;
        step(); idle();
        n_checks++; if (PCF !== 32'h20) begin n_fail++; $display("FAIL wait_pcsrc: got %h want 00000020", PCF); end
        ImemReadyF = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (PCF !== 32'h20 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
                n_fail++; $display("FAIL wait_bubble: got %h/%b/%h want 00000020/0/0", PCF, ValidD, InstrD);
            end
        end
        ImemReadyF = 1;
        step();
        n_checks++; if (PCF !== 32'h24 || InstrD !== instr_of(32'h20) || ValidD !== 1'b1) begin
            n_fail++; $display("FAIL wait_release: got %h/%h/%b want 00000024/%h/1", PCF, InstrD, ValidD, instr_of(32'h20));
        end
        step();
        n_checks++; if (InstrD !== instr_of(32'h24) || PCPlus8D !== 32'h2C) begin
            n_fail++; $display("FAIL wait_next: got %h/%h want %h/0000002c", InstrD, PCPlus8D, instr_of(32'h24));
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] pc0, in0;
        pc0 = PCF; in0 = InstrD;
        StallF = 1; StallD = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (PCF !== pc0 || InstrD !== in0 || ValidD !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold: got %h/%h/%b want %h/%h/1", PCF, InstrD, ValidD, pc0, in0);
            end
        end
        StallF = 0; FlushD = 1;
        step(); idle();
        n_checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus8D !== 32'h0) begin
            n_fail++; $display("FAIL flush_over_stall: got %h/%h/%b want 0/0/0", InstrD, PCPlus8D, ValidD);
        end
        StallF = 1;
        step();
        n_checks++; if (ValidD !== 1'b0 || PCF !== pc0 + 32'd4) begin n_fail++; $display("FAIL stallf_bubble: got %h/%b want %h/0", PCF, ValidD, pc0 + 32'd4); end
        BranchTakenE = 1; ALUResultE = 32'h0000_0400;
        step(); idle();
        n_checks++; if (PCF !== 32'h400) begin n_fail++; $display("FAIL redir_in_stall: got %h want 00000400", PCF); end
    endtask

    task automatic test_wrap_and_reset();
        PCSrcW = 1; ResultW = 32'hFFFF_FFFF;
        step(); idle();
        n_checks++; if (PCF !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want fffffffc", PCF); end
        step();
        n_checks++; if (PCF !== 32'h0 || InstrD !== instr_of(32'hFFFF_FFFC) || PCPlus8D !== 32'h4 || ValidD !== 1'b1) begin
            n_fail++; $display("FAIL wrap: got %h/%h/%h/%b want 0/%h/00000004/1", PCF, InstrD, PCPlus8D, ValidD, instr_of(32'hFFFF_FFFC));
        end
        step(); step();
        StallF = 1; StallD = 1;
        step();
        reset = 1;
        step(); idle();
        n_checks++; if (PCF !== RESET_PC || ValidD !== 1'b0 || InstrD !== 32'h0) begin
            n_fail++; $display("FAIL reset_in_stall: got %h/%b/%h want %h/0/0", PCF, ValidD, InstrD, RESET_PC);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 49) == 0);
            StallF       = ($urandom_range(0, 4) == 0);
            StallD       = ($urandom_range(0, 5) == 0);
            FlushD       = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            PCSrcW       = ($urandom_range(0, 9) == 0);
            ALUResultE   = $urandom;
            ResultW      = $urandom;
            ImemReadyF   = ($urandom_range(0, 3) != 0);
            step();
            n_checks++; if (PCF !== m_pc || InstrD !== m_instr || PCPlus8D !== m_pc8 || ValidD !== m_valid) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b", i, PCF, InstrD, PCPlus8D, ValidD, m_pc, m_instr, m_pc8, m_valid);
            end
        end
        idle();
    endtask

    initial begin
        m_pc = 'x; m_instr = 'x; m_pc8 = 'x; m_valid = 1'bx;
        idle();
        test_reset();
        test_sequential();
        test_branch();
        test_both_redirects();
        test_wait_states();
        test_stall_flush();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
